alu_reservation_station: RTL and testbench
==========================================

Name: alu_reservation_station

Overview:
- Tomasulo reservation station that schedules the shared combinational ALU.
- Buffers up to RS_SIZE dispatched ALU/branch instructions and snoops two result-broadcast buses for pending operands.
- Each cycle, issues at most one ready entry to the ALU through registered issue outputs.
- Sits between the decoder/dispatcher and the ALU; the reorder buffer provides the flush.

Parameters:
- RS_SIZE, 8, number of entries; power of two, 2..16.
- OP_WIDTH, 6, inner-instruction opcode width.
- TAG_WIDTH, 4, ROB tag width.

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  synchronous active-low reset.
- rdy_in  input  1  global ready; low = pause.
- rob_clear_in  input  1  misprediction flush.
- dispatch_valid_in  input  1  new instruction offered.
- dispatch_op_in  input  OP_WIDTH  opcode.
- dispatch_imm_in  input  32  immediate.
- dispatch_pc_in  input  32  instruction pc.
- dispatch_rs1_ready_in  input  1  rs1 value valid.
- dispatch_rs1_val_in  input  32  rs1 value.
- dispatch_rs1_tag_in  input  TAG_WIDTH  rs1 producer tag.
- dispatch_rs2_ready_in  input  1  rs2 value valid.
- dispatch_rs2_val_in  input  32  rs2 value.
- dispatch_rs2_tag_in  input  TAG_WIDTH  rs2 producer tag.
- dispatch_dest_in  input  TAG_WIDTH  destination ROB tag.
- full_out  output  1  no free entry.
- alu_cdb_valid_in  input  1  ALU broadcast valid.
- alu_cdb_tag_in  input  TAG_WIDTH  ALU broadcast tag.
- alu_cdb_val_in  input  32  ALU broadcast value.
- lsb_cdb_valid_in  input  1  load/store buffer broadcast valid.
- lsb_cdb_tag_in  input  TAG_WIDTH  load/store buffer broadcast tag.
- lsb_cdb_val_in  input  32  load/store buffer broadcast value.
- alu_calculate_signal_out  output  1  issue valid.
- alu_op_out  output  OP_WIDTH  issued opcode.
- alu_imm_out  output  32  issued immediate.
- alu_pc_out  output  32  issued pc.
- alu_rs1val_out  output  32  issued rs1 value.
- alu_rs2val_out  output  32  issued rs2 value.
- alu_dest_out  output  TAG_WIDTH  issued destination tag.

Behaviour:
- Reset (rst_in=0 at posedge):
  - All entries invalid.
  - All alu_* outputs 0.
  - full_out becomes 0 as a consequence of all entries invalid.
- Precedence: reset > flush > pause > normal.
- rob_clear_in=1 with rst_in=1: all entries invalidated; alu_calculate_signal_out=0 next cycle; that cycle's dispatch is dropped.
- rdy_in=0: entries, snoop state and alu data outputs hold; alu_calculate_signal_out=0 next cycle; no dispatch accepted.
- full_out is combinational: 1 iff all RS_SIZE entries are valid in the current state.
- Dispatch:
  - Accepted when dispatch_valid_in=1 and full_out=0.
  - Written into the lowest-index free entry.
  - Dispatch into a slot freed by issue in the same cycle is not permitted; full_out uses pre-issue state.
- Snoop:
  - Every posedge, each valid entry with a pending operand whose tag equals a valid CDB tag captures that CDB value and marks the operand ready.
  - Both buses match the same tag: ALU bus wins.
- Dispatch bypass:
  - If a dispatched operand is not ready and its tag matches a valid CDB in the same cycle, the entry stores the CDB value as ready.
  - Prevents a lost wakeup.
- Issue select: lowest-index valid entry with both operands ready, evaluated on the current, pre-snoop state.
  - An entry woken by a snoop is eligible in the next cycle at the earliest.
  - A newly dispatched entry is eligible in the next cycle at the earliest.
- Issue at posedge:
  - Selected entry's fields are registered into the alu_* outputs with alu_calculate_signal_out=1, and the entry is freed.
  - Otherwise alu_calculate_signal_out=0 and the data outputs hold.
- Latency: minimum dispatch-to-issue is 1 cycle (ready operands dispatched at cycle N issue at posedge N+1). The ALU result broadcasts in the same cycle as alu_calculate_signal_out.
- Operand widths are fixed at 32 bits; tags are compared in full TAG_WIDTH bits; no arithmetic is performed in this block.

Test Plan:
- Reset then single dispatch (ADDI, rs1 ready val 5, imm 3, dest 2) -> next cycle calc=1, rs1val=5, imm=3, dest=2; following cycle calc=0.
- Dispatch with rs1 pending tag 7; three cycles later lsb_cdb tag 7 val 0x100 -> calc=1 one cycle after the broadcast, rs1val=0x100.
- Dispatch with rs2 pending tag 4 while alu_cdb (valid, tag 4, val 9) broadcasts in the same cycle -> bypass; issues next cycle with rs2val=9.
- Fill 8 entries all pending -> full_out=1; dispatch dropped. Wake entries 5 and 2 together -> entry 2 issues first, entry 5 the next cycle; full_out=0 after the first issue.
- Flush with 3 entries valid, 1 ready, and a simultaneous dispatch -> no issue, full_out=0; a later broadcast of the old tags produces no issue.
- rdy_in=0 for 2 cycles with a ready entry -> calc=0 during the pause; the entry issues on the first posedge with rdy_in=1.

Source files
------------

// File: rtl/alu_reservation_station_if.sv
// alu_reservation_station_if
//   Dispatch, result-broadcast and ALU-issue signals of the ALU reservation
//   station, bundled so the station and its surroundings share one port.
//   master : the environment (dispatcher, CDB sources, ALU consumer)
//   slave  : the reservation station itself
//   Signals:
//     dispatch_*  : instruction offered by the dispatcher, plus full_out back
//     alu_cdb_*   : ALU result broadcast
//     lsb_cdb_*   : load/store buffer result broadcast
//     alu_*_out   : registered issue to the shared ALU
interface alu_reservation_station_if #(
  parameter int OP_WIDTH  = 6,
  parameter int TAG_WIDTH = 4
);
  logic                 dispatch_valid_in;
  logic [OP_WIDTH-1:0]  dispatch_op_in;
  logic [31:0]          dispatch_imm_in;
  logic [31:0]          dispatch_pc_in;
  logic                 dispatch_rs1_ready_in;
  logic [31:0]          dispatch_rs1_val_in;
  logic [TAG_WIDTH-1:0] dispatch_rs1_tag_in;
  logic                 dispatch_rs2_ready_in;
  logic [31:0]          dispatch_rs2_val_in;
  logic [TAG_WIDTH-1:0] dispatch_rs2_tag_in;
  logic [TAG_WIDTH-1:0] dispatch_dest_in;
  logic                 full_out;

  logic                 alu_cdb_valid_in;
  logic [TAG_WIDTH-1:0] alu_cdb_tag_in;
  logic [31:0]          alu_cdb_val_in;
  logic                 lsb_cdb_valid_in;
  logic [TAG_WIDTH-1:0] lsb_cdb_tag_in;
  logic [31:0]          lsb_cdb_val_in;

  logic                 alu_calculate_signal_out;
  logic [OP_WIDTH-1:0]  alu_op_out;
  logic [31:0]          alu_imm_out;
  logic [31:0]          alu_pc_out;
  logic [31:0]          alu_rs1val_out;
  logic [31:0]          alu_rs2val_out;
  logic [TAG_WIDTH-1:0] alu_dest_out;

  modport master (
    output dispatch_valid_in, dispatch_op_in, dispatch_imm_in, dispatch_pc_in,
           dispatch_rs1_ready_in, dispatch_rs1_val_in, dispatch_rs1_tag_in,
           dispatch_rs2_ready_in, dispatch_rs2_val_in, dispatch_rs2_tag_in,
           dispatch_dest_in,
           alu_cdb_valid_in, alu_cdb_tag_in, alu_cdb_val_in,
           lsb_cdb_valid_in, lsb_cdb_tag_in, lsb_cdb_val_in,
    input  full_out, alu_calculate_signal_out, alu_op_out, alu_imm_out,
           alu_pc_out, alu_rs1val_out, alu_rs2val_out, alu_dest_out
  );

  modport slave (
    input  dispatch_valid_in, dispatch_op_in, dispatch_imm_in, dispatch_pc_in,
           dispatch_rs1_ready_in, dispatch_rs1_val_in, dispatch_rs1_tag_in,
           dispatch_rs2_ready_in, dispatch_rs2_val_in, dispatch_rs2_tag_in,
           dispatch_dest_in,
           alu_cdb_valid_in, alu_cdb_tag_in, alu_cdb_val_in,
           lsb_cdb_valid_in, lsb_cdb_tag_in, lsb_cdb_val_in,
    output full_out, alu_calculate_signal_out, alu_op_out, alu_imm_out,
           alu_pc_out, alu_rs1val_out, alu_rs2val_out, alu_dest_out
  );
endinterface

// File: rtl/alu_reservation_station.sv
// alu_reservation_station
//   Tomasulo reservation station in front of the shared combinational ALU.
//   Holds up to RS_SIZE instructions, wakes pending operands from the ALU and
//   load/store-buffer broadcast buses, and issues at most one ready entry per
//   cycle through registered alu_* outputs.
//   Ports:
//     clk_in       : clock
//     rst_in       : synchronous active-low reset
//     rdy_in       : global ready, low pauses the station
//     rob_clear_in : misprediction flush, drops every entry
//     bus          : dispatch / CDB / issue bundle (slave side)

// One station slot: storage plus its own operand snooping.
module alu_rs_entry #(
  parameter int OP_WIDTH  = 6,
  parameter int TAG_WIDTH = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 flush_in,
  input  logic                 hold_in,
  input  logic                 alloc_in,
  input  logic                 free_in,
  input  logic [OP_WIDTH-1:0]  op_in,
  input  logic [31:0]          imm_in,
  input  logic [31:0]          pc_in,
  input  logic                 rs1_rdy_in,
  input  logic [31:0]          rs1_val_in,
  input  logic [TAG_WIDTH-1:0] rs1_tag_in,
  input  logic                 rs2_rdy_in,
  input  logic [31:0]          rs2_val_in,
  input  logic [TAG_WIDTH-1:0] rs2_tag_in,
  input  logic [TAG_WIDTH-1:0] dest_in,
  input  logic                 alu_cdb_valid_in,
  input  logic [TAG_WIDTH-1:0] alu_cdb_tag_in,
  input  logic [31:0]          alu_cdb_val_in,
  input  logic                 lsb_cdb_valid_in,
  input  logic [TAG_WIDTH-1:0] lsb_cdb_tag_in,
  input  logic [31:0]          lsb_cdb_val_in,
  output logic                 valid_out,
  output logic                 ready_out,
  output logic [OP_WIDTH-1:0]  op_out,
  output logic [31:0]          imm_out,
  output logic [31:0]          pc_out,
  output logic [31:0]          rs1_val_out,
  output logic [31:0]          rs2_val_out,
  output logic [TAG_WIDTH-1:0] dest_out
);
  logic                 valid_q, valid_d;
  logic [OP_WIDTH-1:0]  op_q, op_d;
  logic [31:0]          imm_q, imm_d, pc_q, pc_d;
  logic                 rs1_rdy_q, rs1_rdy_d, rs2_rdy_q, rs2_rdy_d;
  logic [31:0]          rs1_val_q, rs1_val_d, rs2_val_q, rs2_val_d;
  logic [TAG_WIDTH-1:0] rs1_tag_q, rs1_tag_d, rs2_tag_q, rs2_tag_d;
  logic [TAG_WIDTH-1:0] dest_q, dest_d;

  always_comb begin
    valid_d   = valid_q;
    op_d      = op_q;
    imm_d     = imm_q;
    pc_d      = pc_q;
    rs1_rdy_d = rs1_rdy_q;
    rs1_val_d = rs1_val_q;
    rs1_tag_d = rs1_tag_q;
    rs2_rdy_d = rs2_rdy_q;
    rs2_val_d = rs2_val_q;
    rs2_tag_d = rs2_tag_q;
    dest_d    = dest_q;
    if (flush_in) begin
      valid_d = 1'b0;
    end else if (!hold_in) begin
      if (free_in) valid_d = 1'b0;
      // Snoop: the ALU bus is checked first so it wins a same-tag collision.
      if (valid_q && !rs1_rdy_q) begin
        if (alu_cdb_valid_in && alu_cdb_tag_in == rs1_tag_q) begin
          rs1_rdy_d = 1'b1;
          rs1_val_d = alu_cdb_val_in;
        end else if (lsb_cdb_valid_in && lsb_cdb_tag_in == rs1_tag_q) begin
          rs1_rdy_d = 1'b1;
          rs1_val_d = lsb_cdb_val_in;
        end
      end
      if (valid_q && !rs2_rdy_q) begin
        if (alu_cdb_valid_in && alu_cdb_tag_in == rs2_tag_q) begin
          rs2_rdy_d = 1'b1;
          rs2_val_d = alu_cdb_val_in;
        end else if (lsb_cdb_valid_in && lsb_cdb_tag_in == rs2_tag_q) begin
          rs2_rdy_d = 1'b1;
          rs2_val_d = lsb_cdb_val_in;
        end
      end
      // alloc only targets a free slot, so it never collides with snoop/free.
      if (alloc_in) begin
        valid_d   = 1'b1;
        op_d      = op_in;
        imm_d     = imm_in;
        pc_d      = pc_in;
        rs1_rdy_d = rs1_rdy_in;
        rs1_val_d = rs1_val_in;
        rs1_tag_d = rs1_tag_in;
        rs2_rdy_d = rs2_rdy_in;
        rs2_val_d = rs2_val_in;
        rs2_tag_d = rs2_tag_in;
        dest_d    = dest_in;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      valid_q   <= 1'b0;
      op_q      <= '0;
      imm_q     <= '0;
      pc_q      <= '0;
      rs1_rdy_q <= 1'b0;
      rs1_val_q <= '0;
      rs1_tag_q <= '0;
      rs2_rdy_q <= 1'b0;
      rs2_val_q <= '0;
      rs2_tag_q <= '0;
      dest_q    <= '0;
    end else begin
      valid_q   <= valid_d;
      op_q      <= op_d;
      imm_q     <= imm_d;
      pc_q      <= pc_d;
      rs1_rdy_q <= rs1_rdy_d;
      rs1_val_q <= rs1_val_d;
      rs1_tag_q <= rs1_tag_d;
      rs2_rdy_q <= rs2_rdy_d;
      rs2_val_q <= rs2_val_d;
      rs2_tag_q <= rs2_tag_d;
      dest_q    <= dest_d;
    end
  end

  assign valid_out   = valid_q;
  assign ready_out   = valid_q & rs1_rdy_q & rs2_rdy_q;
  assign op_out      = op_q;
  assign imm_out     = imm_q;
  assign pc_out      = pc_q;
  assign rs1_val_out = rs1_val_q;
  assign rs2_val_out = rs2_val_q;
  assign dest_out    = dest_q;
endmodule

module alu_reservation_station #(
  parameter int RS_SIZE   = 8,
  parameter int OP_WIDTH  = 6,
  parameter int TAG_WIDTH = 4
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      rob_clear_in,
  alu_reservation_station_if.slave  bus
);
  localparam int IDX_W = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0]                ent_vld, ent_rdy, alloc_vec, free_vec;
  logic [RS_SIZE-1:0][OP_WIDTH-1:0]  ent_op;
  logic [RS_SIZE-1:0][31:0]          ent_imm, ent_pc, ent_rs1, ent_rs2;
  logic [RS_SIZE-1:0][TAG_WIDTH-1:0] ent_dest;

  logic             full;
  logic             go, issue_any, free_any, issue_fire, alloc_fire;
  logic [IDX_W-1:0] issue_idx, free_idx;

  // Operands after the dispatch-time CDB bypass.
  logic        d_rs1_rdy, d_rs2_rdy;
  logic [31:0] d_rs1_val, d_rs2_val;

  logic                 calc_q, calc_d;
  logic [OP_WIDTH-1:0]  op_q, op_d;
  logic [31:0]          imm_q, imm_d, pc_q, pc_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [TAG_WIDTH-1:0] dest_q, dest_d;

  assign full = &ent_vld;
  assign go   = rdy_in & ~rob_clear_in;

  // Catch a broadcast in the dispatch cycle; the entry would otherwise miss it.
  always_comb begin
    d_rs1_rdy = bus.dispatch_rs1_ready_in;
    d_rs1_val = bus.dispatch_rs1_val_in;
    if (!bus.dispatch_rs1_ready_in) begin
      if (bus.alu_cdb_valid_in && bus.alu_cdb_tag_in == bus.dispatch_rs1_tag_in) begin
        d_rs1_rdy = 1'b1;
        d_rs1_val = bus.alu_cdb_val_in;
      end else if (bus.lsb_cdb_valid_in && bus.lsb_cdb_tag_in == bus.dispatch_rs1_tag_in) begin
        d_rs1_rdy = 1'b1;
        d_rs1_val = bus.lsb_cdb_val_in;
      end
    end
    d_rs2_rdy = bus.dispatch_rs2_ready_in;
    d_rs2_val = bus.dispatch_rs2_val_in;
    if (!bus.dispatch_rs2_ready_in) begin
      if (bus.alu_cdb_valid_in && bus.alu_cdb_tag_in == bus.dispatch_rs2_tag_in) begin
        d_rs2_rdy = 1'b1;
        d_rs2_val = bus.alu_cdb_val_in;
      end else if (bus.lsb_cdb_valid_in && bus.lsb_cdb_tag_in == bus.dispatch_rs2_tag_in) begin
        d_rs2_rdy = 1'b1;
        d_rs2_val = bus.lsb_cdb_val_in;
      end
    end
  end

  // Lowest-index pick: scan downward so the last hit is the lowest index.
  // Both scans use the registered (pre-snoop, pre-issue) entry state.
  always_comb begin
    issue_any = 1'b0;
    issue_idx = '0;
    free_any  = 1'b0;
    free_idx  = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ent_rdy[i]) begin
        issue_any = 1'b1;
        issue_idx = IDX_W'(i);
      end
      if (!ent_vld[i]) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  assign issue_fire = go & issue_any;
  assign alloc_fire = go & bus.dispatch_valid_in & ~full & free_any;

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      alloc_vec[i] = alloc_fire && (free_idx == IDX_W'(i));
      free_vec[i]  = issue_fire && (issue_idx == IDX_W'(i));
    end
  end

  for (genvar g = 0; g < RS_SIZE; g++) begin : g_ent
    alu_rs_entry #(.OP_WIDTH(OP_WIDTH), .TAG_WIDTH(TAG_WIDTH)) u_ent (
      .clk_in           (clk_in),
      .rst_in           (rst_in),
      .flush_in         (rob_clear_in),
      .hold_in          (~rdy_in),
      .alloc_in         (alloc_vec[g]),
      .free_in          (free_vec[g]),
      .op_in            (bus.dispatch_op_in),
      .imm_in           (bus.dispatch_imm_in),
      .pc_in            (bus.dispatch_pc_in),
      .rs1_rdy_in       (d_rs1_rdy),
      .rs1_val_in       (d_rs1_val),
      .rs1_tag_in       (bus.dispatch_rs1_tag_in),
      .rs2_rdy_in       (d_rs2_rdy),
      .rs2_val_in       (d_rs2_val),
      .rs2_tag_in       (bus.dispatch_rs2_tag_in),
      .dest_in          (bus.dispatch_dest_in),
      .alu_cdb_valid_in (bus.alu_cdb_valid_in),
      .alu_cdb_tag_in   (bus.alu_cdb_tag_in),
      .alu_cdb_val_in   (bus.alu_cdb_val_in),
      .lsb_cdb_valid_in (bus.lsb_cdb_valid_in),
      .lsb_cdb_tag_in   (bus.lsb_cdb_tag_in),
      .lsb_cdb_val_in   (bus.lsb_cdb_val_in),
      .valid_out        (ent_vld[g]),
      .ready_out        (ent_rdy[g]),
      .op_out           (ent_op[g]),
      .imm_out          (ent_imm[g]),
      .pc_out           (ent_pc[g]),
      .rs1_val_out      (ent_rs1[g]),
      .rs2_val_out      (ent_rs2[g]),
      .dest_out         (ent_dest[g])
    );
  end

  // Issue register: data only moves on an issue, so pause/flush hold it.
  always_comb begin
    calc_d = issue_fire;
    op_d   = op_q;
    imm_d  = imm_q;
    pc_d   = pc_q;
    rs1_d  = rs1_q;
    rs2_d  = rs2_q;
    dest_d = dest_q;
    if (issue_fire) begin
      op_d   = ent_op[issue_idx];
      imm_d  = ent_imm[issue_idx];
      pc_d   = ent_pc[issue_idx];
      rs1_d  = ent_rs1[issue_idx];
      rs2_d  = ent_rs2[issue_idx];
      dest_d = ent_dest[issue_idx];
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      calc_q <= 1'b0;
      op_q   <= '0;
      imm_q  <= '0;
      pc_q   <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      dest_q <= '0;
    end else begin
      calc_q <= calc_d;
      op_q   <= op_d;
      imm_q  <= imm_d;
      pc_q   <= pc_d;
      rs1_q  <= rs1_d;
      rs2_q  <= rs2_d;
      dest_q <= dest_d;
    end
  end

  assign bus.full_out                 = full;
  assign bus.alu_calculate_signal_out = calc_q;
  assign bus.alu_op_out               = op_q;
  assign bus.alu_imm_out              = imm_q;
  assign bus.alu_pc_out               = pc_q;
  assign bus.alu_rs1val_out           = rs1_q;
  assign bus.alu_rs2val_out           = rs2_q;
  assign bus.alu_dest_out             = dest_q;
endmodule

// File: tb/tb_alu_reservation_station.sv
module tb_alu_reservation_station;
  logic clk_in = 1'b0;
  logic rst_in, rdy_in, rob_clear_in;
  int   checks = 0;
  int   failures = 0;

  alu_reservation_station_if #(.OP_WIDTH(6), .TAG_WIDTH(4)) bus ();

  alu_reservation_station #(.RS_SIZE(8), .OP_WIDTH(6), .TAG_WIDTH(4)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .rob_clear_in (rob_clear_in),
    .bus          (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    bus.dispatch_valid_in = 1'b0;
    bus.alu_cdb_valid_in  = 1'b0;
    bus.lsb_cdb_valid_in  = 1'b0;
    rob_clear_in          = 1'b0;
  endtask

  task automatic set_disp(input logic [5:0] op, input logic [31:0] imm,
                          input logic r1rdy, input logic [31:0] r1val, input logic [3:0] r1tag,
                          input logic r2rdy, input logic [31:0] r2val, input logic [3:0] r2tag,
                          input logic [3:0] dest);
    bus.dispatch_valid_in     = 1'b1;
    bus.dispatch_op_in        = op;
    bus.dispatch_imm_in       = imm;
    bus.dispatch_pc_in        = 32'h1000 + imm;
    bus.dispatch_rs1_ready_in = r1rdy;
    bus.dispatch_rs1_val_in   = r1val;
    bus.dispatch_rs1_tag_in   = r1tag;
    bus.dispatch_rs2_ready_in = r2rdy;
    bus.dispatch_rs2_val_in   = r2val;
    bus.dispatch_rs2_tag_in   = r2tag;
    bus.dispatch_dest_in      = dest;
  endtask

  task automatic alu_bc(input logic [3:0] tag, input logic [31:0] val);
    bus.alu_cdb_valid_in = 1'b1;
    bus.alu_cdb_tag_in   = tag;
    bus.alu_cdb_val_in   = val;
  endtask

  task automatic lsb_bc(input logic [3:0] tag, input logic [31:0] val);
    bus.lsb_cdb_valid_in = 1'b1;
    bus.lsb_cdb_tag_in   = tag;
    bus.lsb_cdb_val_in   = val;
  endtask

  function automatic logic [31:0] calc();
    return 32'(bus.alu_calculate_signal_out);
  endfunction

  function automatic logic [31:0] full();
    return 32'(bus.full_out);
  endfunction

  initial begin
    rst_in = 1'b0;
    rdy_in = 1'b1;
    set_disp(6'd0, 32'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0, 4'd0);
    bus.alu_cdb_tag_in = '0; bus.alu_cdb_val_in = '0;
    bus.lsb_cdb_tag_in = '0; bus.lsb_cdb_val_in = '0;
    idle();
    tick(); tick();
    chk("rst_calc", calc(), 32'd0);
    chk("rst_full", full(), 32'd0);
    chk("rst_rs1", bus.alu_rs1val_out, 32'd0);
    chk("rst_dest", 32'(bus.alu_dest_out), 32'd0);
    chk("rst_imm", bus.alu_imm_out, 32'd0);
    rst_in = 1'b1;

    // Single ready ADDI
    set_disp(6'd1, 32'd3, 1'b1, 32'd5, 4'd0, 1'b1, 32'd0, 4'd0, 4'd2);
    tick(); idle();
    chk("addi_not_same_cycle", calc(), 32'd0);
    tick();
    chk("addi_calc", calc(), 32'd1);
    chk("addi_rs1", bus.alu_rs1val_out, 32'd5);
    chk("addi_imm", bus.alu_imm_out, 32'd3);
    chk("addi_dest", 32'(bus.alu_dest_out), 32'd2);
    chk("addi_op", 32'(bus.alu_op_out), 32'd1);
    chk("addi_pc", bus.alu_pc_out, 32'h1003);
    tick();
    chk("addi_calc_drop", calc(), 32'd0);

    // rs1 pending on tag 7, woken by the LSB bus three cycles later
    set_disp(6'd2, 32'd0, 1'b0, 32'd0, 4'd7, 1'b1, 32'd1, 4'd0, 4'd3);
    tick(); idle();
    tick(); chk("pend_wait1", calc(), 32'd0);
    tick(); chk("pend_wait2", calc(), 32'd0);
    lsb_bc(4'd7, 32'h100);
    tick(); idle();
    chk("pend_bc_cycle", calc(), 32'd0);
    tick();
    chk("pend_calc", calc(), 32'd1);
    chk("pend_rs1", bus.alu_rs1val_out, 32'h100);
    chk("pend_dest", 32'(bus.alu_dest_out), 32'd3);

    // Dispatch-cycle bypass from the ALU bus
    set_disp(6'd3, 32'd0, 1'b1, 32'd1, 4'd0, 1'b0, 32'd0, 4'd4, 4'd4);
    alu_bc(4'd4, 32'd9);
    tick(); idle();
    tick();
    chk("byp_calc", calc(), 32'd1);
    chk("byp_rs2", bus.alu_rs2val_out, 32'd9);

    // Same tag on both buses: ALU value wins
    set_disp(6'd4, 32'd0, 1'b0, 32'd0, 4'd9, 1'b1, 32'd0, 4'd0, 4'd5);
    tick(); idle();
    alu_bc(4'd9, 32'hA1);
    lsb_bc(4'd9, 32'hB2);
    tick(); idle();
    tick();
    chk("both_calc", calc(), 32'd1);
    chk("both_rs1", bus.alu_rs1val_out, 32'hA1);

    // Fill all 8 with rs1 pending on tag i+1, dest i+8
    for (int i = 0; i < 8; i++) begin
      set_disp(6'd5, 32'(i), 1'b0, 32'd0, 4'(i + 1), 1'b1, 32'd0, 4'd0, 4'(i + 8));
      tick();
    end
    idle();
    chk("fill_full", full(), 32'd1);
    set_disp(6'd6, 32'd0, 1'b1, 32'd0, 4'd0, 1'b1, 32'd0, 4'd0, 4'd15);
    tick(); idle();
    chk("fill_drop_full", full(), 32'd1);
    tick();
    chk("fill_drop_calc", calc(), 32'd0);
    alu_bc(4'd3, 32'h33);   // entry 2
    lsb_bc(4'd6, 32'h66);   // entry 5
    tick(); idle();
    chk("wake_same_cycle", calc(), 32'd0);
    tick();
    chk("wake1_calc", calc(), 32'd1);
    chk("wake1_dest", 32'(bus.alu_dest_out), 32'd10);
    chk("wake1_rs1", bus.alu_rs1val_out, 32'h33);
    chk("wake1_full", full(), 32'd0);
    tick();
    chk("wake2_calc", calc(), 32'd1);
    chk("wake2_dest", 32'(bus.alu_dest_out), 32'd13);
    chk("wake2_rs1", bus.alu_rs1val_out, 32'h66);
    tick();
    chk("wake_done", calc(), 32'd0);
    rob_clear_in = 1'b1;
    tick(); idle();
    chk("clean_full", full(), 32'd0);

    // Flush with 3 entries (one ready) and a simultaneous dispatch
    set_disp(6'd7, 32'd0, 1'b0, 32'd0, 4'd1, 1'b1, 32'd0, 4'd0, 4'd1);
    tick();
    set_disp(6'd7, 32'd0, 1'b0, 32'd0, 4'd2, 1'b1, 32'd0, 4'd0, 4'd2);
    tick();
    set_disp(6'd7, 32'd0, 1'b1, 32'h77, 4'd0, 1'b1, 32'd0, 4'd0, 4'd3);
    tick();
    chk("pre_flush_calc", calc(), 32'd0);
    set_disp(6'd8, 32'd0, 1'b1, 32'h55, 4'd0, 1'b1, 32'd0, 4'd0, 4'd5);
    rob_clear_in = 1'b1;
    tick(); idle();
    chk("flush_calc", calc(), 32'd0);
    chk("flush_full", full(), 32'd0);
    tick();
    chk("flush_drop_disp", calc(), 32'd0);
    alu_bc(4'd1, 32'h11);
    lsb_bc(4'd2, 32'h22);
    tick(); idle();
    tick();
    chk("flush_stale_tag1", calc(), 32'd0);
    tick();
    chk("flush_stale_tag2", calc(), 32'd0);

    // Pause for two cycles with a ready entry
    set_disp(6'd9, 32'd0, 1'b1, 32'hAB, 4'd0, 1'b1, 32'd0, 4'd0, 4'd6);
    tick(); idle();
    rdy_in = 1'b0;
    tick();
    chk("pause1_calc", calc(), 32'd0);
    chk("pause1_dest_hold", 32'(bus.alu_dest_out), 32'd13);
    tick();
    chk("pause2_calc", calc(), 32'd0);
    rdy_in = 1'b1;
    tick();
    chk("resume_calc", calc(), 32'd1);
    chk("resume_dest", 32'(bus.alu_dest_out), 32'd6);
    chk("resume_rs1", bus.alu_rs1val_out, 32'hAB);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
